// File: rtl/pool1.sv
//==============================================================================
// Module   : pool1
// Brief    : 2x2 stride-2 signed max pooling of 16x26x26 maps with shift+sat8
// Revision : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module pool1 #(
    parameter int SHIFT = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               t,
    output logic               d,
    input  logic signed [31:0] input_map [0:15][0:25][0:25],
    output logic signed [7:0]  pool_map  [0:15][0:12][0:12]
);

    typedef enum logic [1:0] {
        IDLE             = 2'd0,
        COMPUTING        = 2'd1,
        DONE             = 2'd2,
        WAIT_TRIGGER_LOW = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [3:0]         r_c;
    logic [3:0]         r_r;
    logic [3:0]         r_q;
    logic [4:0]         w_row0;
    logic [4:0]         w_row1;
    logic [4:0]         w_col0;
    logic [4:0]         w_col1;
    logic signed [31:0] w_max_top;
    logic signed [31:0] w_max_bot;
    logic signed [31:0] w_max;
    logic signed [31:0] w_shifted;
    logic signed [7:0]  w_sat;
    logic               w_last;

    assign w_row0 = {r_r, 1'b0};
    assign w_row1 = {r_r, 1'b1};
    assign w_col0 = {r_q, 1'b0};
    assign w_col1 = {r_q, 1'b1};
    assign w_last = (r_c == 4'd15) && (r_r == 4'd12) && (r_q == 4'd12);

    // Window maximum, then sign-preserving requantization and clamp to int8
    always_comb begin
        w_max_top = (input_map[r_c][w_row0][w_col0] > input_map[r_c][w_row0][w_col1])
                  ? input_map[r_c][w_row0][w_col0] : input_map[r_c][w_row0][w_col1];
        w_max_bot = (input_map[r_c][w_row1][w_col0] > input_map[r_c][w_row1][w_col1])
                  ? input_map[r_c][w_row1][w_col0] : input_map[r_c][w_row1][w_col1];
        w_max     = (w_max_top > w_max_bot) ? w_max_top : w_max_bot;
        w_shifted = w_max >>> SHIFT;
        if (w_shifted > 32'sd127) begin
            w_sat = 8'sd127;
        end else if (w_shifted < -32'sd128) begin
            w_sat = -8'sd128;
        end else begin
            w_sat = w_shifted[7:0];
        end
    end

    always_comb begin
        w_next = r_state;
        d      = 1'b0;
        case (r_state)
            IDLE: begin
                if (t) begin
                    w_next = COMPUTING;
                end
            end
            COMPUTING: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                d      = 1'b1;
                w_next = WAIT_TRIGGER_LOW;
            end
            WAIT_TRIGGER_LOW: begin
                if (!t) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_c     <= 4'd0;
            r_r     <= 4'd0;
            r_q     <= 4'd0;
            for (int c = 0; c < 16; c++) begin
                for (int r = 0; r < 13; r++) begin
                    for (int q = 0; q < 13; q++) begin
                        pool_map[c][r][q] <= 8'sd0;
                    end
                end
            end
        end else begin
            r_state <= w_next;
            if (r_state == COMPUTING) begin
                pool_map[r_c][r_r][r_q] <= w_sat;
                // q fastest, then r, then c; the final write wraps all to zero
                if (r_q == 4'd12) begin
                    r_q <= 4'd0;
                    if (r_r == 4'd12) begin
                        r_r <= 4'd0;
                        r_c <= r_c + 4'd1;
                    end else begin
                        r_r <= r_r + 4'd1;
                    end
                end else begin
                    r_q <= r_q + 4'd1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/pool1.md
POOL1 -- requirements
Module: pool1

Interface
REQ-001 Parameter: SHIFT, default 8, arithmetic right-shift applied to each pooled 32-bit maximum before saturation to 8 bits.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-004 Port: t  input  1  trigger; a pooling pass starts when t is sampled high in IDLE.
REQ-005 Port: d  output  1  done; high for exactly one cycle when the pass completes.
REQ-006 Port: input_map  input  signed 32 x [0:15][0:25][0:25]  16 conv feature maps, 26x26, indexed [channel][row][col].
REQ-007 Port: pool_map  output  signed 8 x [0:15][0:12][0:12]  16 pooled, requantized maps, 13x13, registered.

Function
REQ-008 Block SHALL implement 2x2 max pooling, stride 2: pool_map[c][r][q] = sat8(max(input_map[c][2r][2q], [c][2r][2q+1], [c][2r+1][2q], [c][2r+1][2q+1]) >>> SHIFT).
REQ-009 Comparisons SHALL be signed 32-bit; >>> SHALL be arithmetic (sign-preserving).
REQ-010 sat8 SHALL clamp to [-128, 127]: values >127 give 127, values <-128 give -128, else low 8 bits.
REQ-011 FSM SHALL have states IDLE, COMPUTING, DONE, WAIT_TRIGGER_LOW.
REQ-012 IDLE -> COMPUTING when t=1 at a clock edge; otherwise stay in IDLE.
REQ-013 COMPUTING SHALL write exactly one pool_map element per cycle, at index (c, r, q) taken from internal counters.
REQ-014 Counters SHALL advance q fastest (0..12), then r (0..12), then c (0..15); 2704 writes per pass.
REQ-015 COMPUTING -> DONE on the edge that writes (15,12,12); on that edge all counters SHALL wrap to 0.
REQ-016 DONE -> WAIT_TRIGGER_LOW unconditionally after one cycle; d=1 only while state is DONE.
REQ-017 WAIT_TRIGGER_LOW -> IDLE when t=0; with t held high the block SHALL NOT start a second pass.
REQ-018 Latency: if t is sampled high at edge E0, writes SHALL occur at edges E1..E2704 and d SHALL be high from E2704 to E2705.
REQ-019 pool_map elements not yet written in the current pass SHALL retain their previous values.
REQ-020 t SHALL be ignored in COMPUTING and DONE; a toggle of t mid-pass SHALL NOT restart or abort the pass.
REQ-021 input_map SHALL be held stable by upstream from the start edge until d; the block SHALL NOT buffer it.

Reset
REQ-022 On reset=0, asynchronously: state=IDLE, d=0, c=r=q=0, all pool_map elements=0.
REQ-023 Reset asserted mid-pass SHALL abort the pass; after release the block SHALL wait in IDLE for a new t.
REQ-024 Deassertion of reset SHALL take effect on the next rising clk edge; no pass SHALL start on the release edge unless t=1 is sampled there in IDLE.

Verification
REQ-025 All input_map = 0x100, SHIFT=8, pulse t -> every pool_map element = 1 after d; d high exactly one cycle, 2704 cycles after the start edge.
REQ-026 input_map[c][y][x] = c*1000 + y*26 + x, SHIFT=0 -> pool_map[3][5][7] = sat8(3000+11*26+15) = 127; pool_map[0][0][0] = sat8(27) = 27.
REQ-027 Block with values {-5000, -300, -400, -256} at (0,0,0) window, SHIFT=8 -> max -256 >>> 8 = -1; {0x7FFFFFFF x4} -> 127; {0x80000000 x4} -> -128.
REQ-028 Hold t=1 for 5000 cycles -> exactly one pass, one d pulse; drop t, raise t again -> second pass, second d pulse.
REQ-029 Assert reset at cycle 1000 of a pass -> d never pulses, pool_map reads all 0, state IDLE; a fresh t completes a full pass with correct results.
